// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: bundles the MEM-stage inputs, the data-memory read
// response and the writeback outputs of the MEM/WB stage.
// master = upstream pipeline / memory side, slave = the mem_wb_stage itself.
interface mem_wb_stage_if;
  // MEM-stage instruction fields
  logic        RegWrite_MEM;
  logic        MemtoReg_MEM;
  logic        MemRead_MEM;
  logic [4:0]  RD_MEM;
  logic [2:0]  FUNCT3_MEM;
  logic [31:0] ALU_RESULT_MEM;
  // data-memory read response
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  // writeback / hazard outputs
  logic        RegWrite_WB;
  logic [4:0]  RD_WB;
  logic [31:0] ALU_DATA_WB;
  logic        wb_stall;
  logic        load_timeout;

  modport master (
    output RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, RD_MEM, FUNCT3_MEM,
           ALU_RESULT_MEM, mem_rdata, mem_rvalid,
    input  RegWrite_WB, RD_WB, ALU_DATA_WB, wb_stall, load_timeout
  );

  modport slave (
    input  RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, RD_MEM, FUNCT3_MEM,
           ALU_RESULT_MEM, mem_rdata, mem_rvalid,
    output RegWrite_WB, RD_WB, ALU_DATA_WB, wb_stall, load_timeout
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback unit.
// Non-load results and same-cycle load hits are written back one cycle later.
// A load without an immediate response parks the stage in WAIT_LOAD (wb_stall=1)
// until mem_rvalid arrives or TIMEOUT cycles elapse, in which case the load is
// dropped and load_timeout pulses once.
// Optional feature macro: LOAD_EXT_EN -- sub-word load lane select and
// sign/zero extension (LB/LH/LW/LBU/LHU). Undefined: loads are word-only.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic     clk,
  input logic     reset,
  mem_wb_stage_if.slave bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [4:0]         rd_lat_reg;
  logic               regwrite_lat_reg;

  logic               regwrite_wb_reg;
  logic [4:0]         rd_wb_reg;
  logic [31:0]        data_wb_reg;
  logic               timeout_reg;

  // Extended write data for a same-cycle hit and for a late response.
  logic [31:0]        hit_data;
  logic [31:0]        wait_data;

`ifdef LOAD_EXT_EN
  logic [2:0]         funct3_lat_reg;
  logic [1:0]         addr_lat_reg;

  // Lane select plus sign/zero extension of a load response.
  function automatic logic [31:0] ext_load(input logic [31:0] d,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  a);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = d >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? d[31:16] : d[15:0];
    r  = d;
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Hit path uses the live MEM fields, late path the ones latched on entry.
  always_comb begin
    hit_data  = ext_load(bus.mem_rdata, bus.FUNCT3_MEM, bus.ALU_RESULT_MEM[1:0]);
    wait_data = ext_load(bus.mem_rdata, funct3_lat_reg, addr_lat_reg);
  end
`else
  // Word-only loads: response data is written back unchanged.
  logic unused_funct3;
  assign unused_funct3 = ^bus.FUNCT3_MEM;
  assign hit_data      = bus.mem_rdata;
  assign wait_data     = bus.mem_rdata;
`endif

  // Pipeline register, load-wait FSM and timeout counter.
  // A late response always carries load data into writeback: only the low
  // address bits of the ALU result are retained while waiting, so there is
  // no ALU value to fall back on and MemtoReg is not latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      rd_lat_reg       <= '0;
      regwrite_lat_reg <= 1'b0;
`ifdef LOAD_EXT_EN
      funct3_lat_reg   <= '0;
      addr_lat_reg     <= '0;
`endif
      regwrite_wb_reg  <= 1'b0;
      rd_wb_reg        <= '0;
      data_wb_reg      <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.MemRead_MEM) begin
            // ALU result; any response strobe here is stray and ignored
            regwrite_wb_reg <= bus.RegWrite_MEM && (bus.RD_MEM != 5'd0);
            rd_wb_reg       <= bus.RD_MEM;
            data_wb_reg     <= bus.ALU_RESULT_MEM;
          end else if (bus.mem_rvalid) begin
            // same-cycle load hit, no stall
            regwrite_wb_reg <= bus.RegWrite_MEM && (bus.RD_MEM != 5'd0);
            rd_wb_reg       <= bus.RD_MEM;
            data_wb_reg     <= bus.MemtoReg_MEM ? hit_data : bus.ALU_RESULT_MEM;
          end else begin
            state_reg        <= WAIT_LOAD;
            cnt_reg          <= '0;
            rd_lat_reg       <= bus.RD_MEM;
            regwrite_lat_reg <= bus.RegWrite_MEM;
`ifdef LOAD_EXT_EN
            funct3_lat_reg   <= bus.FUNCT3_MEM;
            addr_lat_reg     <= bus.ALU_RESULT_MEM[1:0];
`endif
            regwrite_wb_reg  <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_rvalid) begin
            // response wins over a coincident timeout
            state_reg       <= IDLE;
            regwrite_wb_reg <= regwrite_lat_reg && (rd_lat_reg != 5'd0);
            rd_wb_reg       <= rd_lat_reg;
            data_wb_reg     <= wait_data;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            state_reg       <= IDLE;
            regwrite_wb_reg <= 1'b0;
            timeout_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.RegWrite_WB  = regwrite_wb_reg;
  assign bus.RD_WB        = rd_wb_reg;
  assign bus.ALU_DATA_WB  = data_wb_reg;
  assign bus.load_timeout = timeout_reg;
  assign bus.wb_stall     = (state_reg == WAIT_LOAD);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. The stimulus process
// pushes the expected writeback/timeout events; a negedge monitor pops and
// compares whenever the DUT asserts RegWrite_WB or load_timeout.
// Honours LOAD_EXT_EN the same way as the design.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 16;
`ifdef LOAD_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_timeout;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference load extension from the ISA rules: pick the addressed lane,
  // then sign- or zero-extend according to funct3.
  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    if (!EXT_EN) return d;
    b = 8'((d >> (8 * int'(a))) & 32'hFF);
    h = 16'((d >> (16 * int'(a[1]))) & 32'hFFFF);
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Monitor: every writeback or timeout strobe must match the next expected event.
  always @(negedge clk) begin
    if (!reset && (bus.RegWrite_WB || bus.load_timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got we=%0b to=%0b rd=%0d data=0x%08h expected none",
                 bus.RegWrite_WB, bus.load_timeout, bus.RD_WB, bus.ALU_DATA_WB);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_timeout) begin
          $display("TXN timeout");
          check("timeout_pulse", 32'(bus.load_timeout), 32'd1);
          check("timeout_no_write", 32'(bus.RegWrite_WB), 32'd0);
        end else begin
          $display("TXN wb rd=%0d data=0x%08h", bus.RD_WB, bus.ALU_DATA_WB);
          check("wb_kind", {30'd0, bus.RegWrite_WB, bus.load_timeout}, 32'd2);
          check("wb_rd", 32'(bus.RD_WB), 32'(e.rd));
          check("wb_data", bus.ALU_DATA_WB, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.RegWrite_MEM   = 1'b0;
    bus.MemtoReg_MEM   = 1'b0;
    bus.MemRead_MEM    = 1'b0;
    bus.RD_MEM         = 5'd0;
    bus.FUNCT3_MEM     = 3'd0;
    bus.ALU_RESULT_MEM = 32'd0;
    bus.mem_rdata      = 32'd0;
    bus.mem_rvalid     = 1'b0;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.is_timeout = 1'b0;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_timeout();
    exp_t e;
    e.is_timeout = 1'b1;
    e.rd = 5'd0;
    e.data = 32'd0;
    exp_q.push_back(e);
  endtask

  // One MEM-stage instruction. For loads, delay=0 is a same-cycle hit,
  // 1..TIMEOUT is the response edge after the load edge, larger = no response.
  task automatic issue(input bit mr, input bit rw, input bit m2r, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] alu, input int delay,
                       input logic [31:0] rdata);
    int stall_cnt;
    int exp_stall;
    bus.MemRead_MEM    = mr;
    bus.RegWrite_MEM   = rw;
    bus.MemtoReg_MEM   = m2r;
    bus.RD_MEM         = rd;
    bus.FUNCT3_MEM     = f3;
    bus.ALU_RESULT_MEM = alu;
    if (!mr) begin
      bus.mem_rdata  = $urandom;
      bus.mem_rvalid = ($urandom_range(0, 3) == 0);
      if (rw && rd != 5'd0) push_wb(rd, alu);
      step();
      bus.mem_rvalid = 1'b0;
    end else if (delay == 0) begin
      bus.mem_rdata  = rdata;
      bus.mem_rvalid = 1'b1;
      if (rw && rd != 5'd0) push_wb(rd, m2r ? ref_ext(rdata, f3, alu[1:0]) : alu);
      step();
      bus.mem_rvalid = 1'b0;
      check("hit_no_stall", 32'(bus.wb_stall), 32'd0);
    end else begin
      if (delay <= TIMEOUT) begin
        if (rw && rd != 5'd0) push_wb(rd, ref_ext(rdata, f3, alu[1:0]));
      end else begin
        push_timeout();
      end
      bus.mem_rvalid = 1'b0;
      step();
      stall_cnt = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
        if (bus.wb_stall) stall_cnt++;
        // upstream contents during the wait must not matter
        bus.MemRead_MEM    = 1'($urandom);
        bus.RegWrite_MEM   = 1'($urandom);
        bus.RD_MEM         = 5'($urandom);
        bus.ALU_RESULT_MEM = $urandom;
        bus.mem_rvalid     = (k == delay);
        bus.mem_rdata      = (k == delay) ? rdata : $urandom;
        step();
        if (k == delay) break;
      end
      bus.mem_rvalid = 1'b0;
      exp_stall = (delay < TIMEOUT) ? delay : TIMEOUT;
      check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
      check("stall_released", 32'(bus.wb_stall), 32'd0);
    end
    drive_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(bus.RegWrite_WB), 32'd0);
    check({tag, "_rd"}, 32'(bus.RD_WB), 32'd0);
    check({tag, "_data"}, bus.ALU_DATA_WB, 32'd0);
    check({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
    check({tag, "_timeout"}, 32'(bus.load_timeout), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // ALU writeback and RD=0 suppression
    issue(0, 1, 0, 5'd5, 3'd0, 32'h1234_5678, 0, 32'd0);
    check("alu_we", 32'(bus.RegWrite_WB), 32'd1);
    issue(0, 1, 0, 5'd0, 3'd0, 32'h0BAD_F00D, 0, 32'd0);
    check("rd0_no_write", 32'(bus.RegWrite_WB), 32'd0);
    check("rd0_data", bus.ALU_DATA_WB, 32'h0BAD_F00D);

    // late word load and a timeout followed by a normal ALU op
    issue(1, 1, 1, 5'd7, 3'b010, 32'h0000_1000, 4, 32'hCAFE_BABE);
    issue(1, 1, 1, 5'd9, 3'b010, 32'h0000_2000, 100, 32'd0);
    issue(0, 1, 0, 5'd3, 3'd0, 32'hA5A5_0001, 0, 32'd0);
    // response on the last allowed cycle beats the timeout
    issue(1, 1, 1, 5'd11, 3'b010, 32'h0000_3000, TIMEOUT, 32'h1357_9BDF);

    // same-cycle hit and stray response
    issue(1, 1, 1, 5'd12, 3'b010, 32'h0000_4000, 0, 32'hDEAD_BEEF);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    step();
    drive_idle();
    check("stray_ignored_stall", 32'(bus.wb_stall), 32'd0);

    // sub-word loads (plain word data when the extension is disabled)
    issue(1, 1, 1, 5'd13, 3'b000, 32'h0000_0101, 0, 32'h0000_80FF);
    issue(1, 1, 1, 5'd14, 3'b100, 32'h0000_0101, 2, 32'h0000_80FF);
    issue(1, 1, 1, 5'd15, 3'b101, 32'h0000_0102, 0, 32'hBEEF_0000);
    issue(1, 1, 1, 5'd16, 3'b001, 32'h0000_0102, 5, 32'h8001_0000);

    // reset for two cycles in the middle of a wait drops the load
    issue(0, 1, 0, 5'd20, 3'd0, 32'h7777_8888, 0, 32'd0);
    bus.MemRead_MEM  = 1'b1;
    bus.RegWrite_MEM = 1'b1;
    bus.MemtoReg_MEM = 1'b1;
    bus.RD_MEM       = 5'd21;
    step();
    step();
    check("pre_reset_stall", 32'(bus.wb_stall), 32'd1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    drive_idle();
    check_all_zero("mid_reset");
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    step();
    drive_idle();
    step();
    check("post_reset_no_wb", 32'(bus.RegWrite_WB), 32'd0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit          mr;
      int          sel;
      int          dly;
      logic [4:0]  rd;
      mr  = ($urandom_range(0, 9) < 4);
      sel = $urandom_range(0, 9);
      dly = (sel < 3) ? 0 : (sel < 8) ? $urandom_range(1, TIMEOUT) : TIMEOUT + 5;
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue(mr, 1'($urandom), ($urandom_range(0, 4) != 0), rd, 3'($urandom),
            $urandom, dly, $urandom);
    end

    step();
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
